// File: rtl/rx_fifo.sv
// Receive-side first-word-fall-through byte FIFO fed by the USB receiver controller.
// Reports occupancy and raises a sticky overrun flag when a byte arrives with no free slot.
module rx_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_enable,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  overrun
);

    localparam int AW = CNT_W - 1;

    logic [CNT_W-1:0]      wptr_reg, wptr_next;
    logic [CNT_W-1:0]      rptr_reg, rptr_next;
    logic                  overrun_reg, overrun_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic          push;
    logic          pop;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    assign waddr = wptr_reg[AW-1:0];
    assign raddr = rptr_reg[AW-1:0];

    // Status is derived purely from the pointers, so w_enable never reaches it combinationally.
    assign empty = (wptr_reg == rptr_reg);
    assign full  = (waddr == raddr) && (wptr_reg[AW] != rptr_reg[AW]);
    assign count = wptr_reg - rptr_reg;

    // A pop in the same cycle frees the head slot, so a write into a full FIFO still lands.
    assign pop  = r_enable && !empty && !flush;
    assign push = w_enable && (!full || pop) && !flush;

    always_comb begin
        wptr_next    = wptr_reg;
        rptr_next    = rptr_reg;
        overrun_next = overrun_reg;
        if (flush) begin
            wptr_next    = '0;
            rptr_next    = '0;
            overrun_next = 1'b0;
        end else begin
            if (push) begin
                wptr_next = wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_next = rptr_reg + 1'b1;
            end
            if (w_enable && !push) begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            overrun_reg <= overrun_next;
        end
    end

    // Storage carries no reset; stale contents are never visible because the pointers gate them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (waddr == AW'(gi))) begin
                    mem[gi] <= w_data;
                end
            end
        end
    endgenerate

    assign r_data  = empty ? '0 : mem[raddr];
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed testbench for rx_fifo: a queue-based reference model checked on every
// falling edge, plus literal expectations taken from hand-worked sequences.
module tb_rx_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  w_enable = 1'b0;
    logic [DATA_WIDTH-1:0] w_data = '0;
    logic                  r_enable = 1'b0;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic                  overrun;

    int errors = 0;
    int checks = 0;

    rx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .w_enable (w_enable),
        .w_data   (w_data),
        .r_enable (r_enable),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of stored bytes and a sticky overrun bit.
    logic [DATA_WIDTH-1:0] model_q[$];
    bit                    model_ovr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            model_ovr = 1'b0;
        end else if (flush) begin
            model_q.delete();
            model_ovr = 1'b0;
        end else begin
            bit popped;
            bit room;
            popped = r_enable && (model_q.size() > 0);
            room   = (model_q.size() < DEPTH) || popped;
            if (popped) void'(model_q.pop_front());
            if (w_enable) begin
                if (room) model_q.push_back(w_data);
                else      model_ovr = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DATA_WIDTH-1:0] exp_data;
        exp_data = (model_q.size() > 0) ? model_q[0] : '0;
        check("model_r_data",  32'(r_data),  32'(exp_data));
        check("model_empty",   32'(empty),   32'(model_q.size() == 0));
        check("model_full",    32'(full),    32'(model_q.size() == DEPTH));
        check("model_count",   32'(count),   32'(model_q.size()));
        check("model_overrun", 32'(overrun), 32'(model_ovr));
    end

    // Inputs are applied just after a falling edge, held across one rising edge, then released.
    task automatic drive(input bit we, input logic [DATA_WIDTH-1:0] wd, input bit re, input bit fl);
        w_enable = we;
        w_data   = wd;
        r_enable = re;
        flush    = fl;
        @(negedge clk);
        #1;
        w_enable = 1'b0;
        w_data   = '0;
        r_enable = 1'b0;
        flush    = 1'b0;
        $display("txn we=%0d wd=0x%02h re=%0d fl=%0d -> r_data=0x%02h count=%0d empty=%0d full=%0d ovr=%0d",
                 we, wd, re, fl, r_data, count, empty, full, overrun);
    endtask

    initial begin
        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rdata", 32'(r_data), 32'd0);
        check("rst_full",  32'(full), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Basic order
        drive(1, 8'hA5, 0, 0);
        drive(1, 8'h3C, 0, 0);
        drive(1, 8'h80, 0, 0);
        check("basic_count", 32'(count), 32'd3);
        check("basic_head",  32'(r_data), 32'hA5);
        drive(0, 0, 1, 0);
        check("basic_pop1", 32'(r_data), 32'h3C);
        drive(0, 0, 1, 0);
        check("basic_pop2", 32'(r_data), 32'h80);
        drive(0, 0, 1, 0);
        check("basic_pop3", 32'(r_data), 32'h00);
        check("basic_empty", 32'(empty), 32'd1);

        // Fill and overrun
        for (int i = 0; i < 8; i++) drive(1, 8'(i), 0, 0);
        check("fill_full",  32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        drive(1, 8'hFF, 0, 0);
        check("fill_ovr",   32'(overrun), 32'd1);
        check("fill_count_after_drop", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("fill_order", 32'(r_data), 32'(i));
            drive(0, 0, 1, 0);
        end
        check("fill_ovr_sticky", 32'(overrun), 32'd1);
        drive(0, 0, 0, 1);
        check("flush_ovr", 32'(overrun), 32'd0);

        // Full with simultaneous write and pop
        for (int i = 0; i < 8; i++) drive(1, 8'(8'h10 + i), 0, 0);
        drive(1, 8'h55, 1, 0);
        check("fullsim_count", 32'(count), 32'd8);
        check("fullsim_ovr",   32'(overrun), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check("fullsim_order", 32'(r_data), 32'(8'h10 + i));
            drive(0, 0, 1, 0);
        end
        check("fullsim_last", 32'(r_data), 32'h55);
        drive(0, 0, 1, 0);

        // Empty corner cases
        drive(0, 0, 1, 0);
        check("empty_pop_count", 32'(count), 32'd0);
        drive(1, 8'h11, 1, 0);
        check("empty_wr_pop_count", 32'(count), 32'd1);
        check("empty_wr_pop_data",  32'(r_data), 32'h11);
        drive(0, 0, 1, 0);

        // Wrap-around with interleaved write/pop pairs
        drive(1, 8'd0, 0, 0);
        for (int i = 1; i < 20; i++) begin
            check("wrap_order", 32'(r_data), 32'(i - 1));
            drive(1, 8'(i), 1, 0);
        end
        check("wrap_last", 32'(r_data), 32'd19);
        drive(0, 0, 1, 0);
        check("wrap_empty", 32'(empty), 32'd1);

        // Reset mid-operation is asynchronous
        for (int i = 0; i < 5; i++) drive(1, 8'(8'hC0 + i), 0, 0);
        rst = 1'b1;
        #2;
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_rdata", 32'(r_data), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1, 8'h42, 0, 0);
        check("postrst_data", 32'(r_data), 32'h42);

        // Flush with a concurrent write
        for (int i = 0; i < 3; i++) drive(1, 8'(8'hE0 + i), 0, 0);
        drive(1, 8'h99, 0, 1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        drive(1, 8'h77, 0, 0);
        check("postflush_data",  32'(r_data), 32'h77);
        check("postflush_count", 32'(count), 32'd1);

        drive(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
Receive-side byte buffer directly downstream of the USB receiver controller. It captures each byte when the controller pulses w_enable with the received byte. It then presents the bytes in order to the host-side reader with first-word-fall-through semantics. It also reports full/empty/occupancy and flags a sticky overrun when a byte arrives with no free slot.

Parameters:
DATA_WIDTH, 8, width of each stored word (bits).
DEPTH, 8, number of entries; power of two, >= 2.
CNT_W, $clog2(DEPTH)+1, width of count output (derived; not overridden).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of contents and overrun flag.
w_enable  input  1  write strobe from the receiver controller, one cycle per byte.
w_data  input  DATA_WIDTH  byte to store, valid when w_enable=1.
r_enable  input  1  read/pop strobe from the reader.
r_data  output  DATA_WIDTH  head-of-queue word, valid when empty=0.
empty  output  1  no stored words.
full  output  1  DEPTH stored words.
count  output  CNT_W  number of stored words, 0..DEPTH.
overrun  output  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = (wptr == rptr); full = (index bits equal, wrap bits differ); count = wptr - rptr (modulo 2^CNT_W). All three are combinational from the pointers.
- r_data = mem[rptr index] when empty=0. When empty=1, r_data = 0. This is first-word-fall-through: data is visible before r_enable, and r_enable pops it.
- Write accepted when w_enable=1 and (full=0 or a pop is accepted in the same cycle). On acceptance: mem[wptr]<=w_data, wptr<=wptr+1. The word is visible on r_data the next cycle if the FIFO was empty.
- Pop accepted when r_enable=1 and empty=0. On acceptance: rptr<=rptr+1. r_enable while empty is ignored: no pointer change, no error.
- Simultaneous write+pop, not empty: both accepted, count unchanged. This holds even when full, where the popped slot frees space and the write is not dropped.
- Simultaneous write+pop while empty: write accepted, pop ignored, count becomes 1.
- Write while full with no accepted pop: the word is dropped, memory and pointers are unchanged, and overrun<=1.
- overrun stays 1 until flush or rst. Reads do not clear it.
- Pointer wrap: pointers increment modulo 2^CNT_W. Index wrap from DEPTH-1 to 0 is seamless, with no lost or duplicated words.
- flush=1 has priority over everything in that cycle. Next cycle: wptr=rptr=0, overrun=0, count=0. Any write or pop in the flush cycle is discarded. Memory contents need not be cleared.
- Reset (rst=1, asynchronous, effective immediately and held while asserted): wptr=0, rptr=0, overrun=0. Outputs then read empty=1, full=0, count=0, r_data=0. Memory contents are don't-care.
- Reset mid-operation discards all stored words. The first write after rst deasserts lands in entry 0.
- Latency: write-to-visible on r_data is 1 cycle. Pop-to-next-word is 1 cycle.
- No combinational path from w_enable to r_data or empty in the same cycle.

Test Plan:
- Basic order: after rst, write 0xA5, 0x3C, 0x80 on consecutive cycles -> count=3, r_data=0xA5. Pop three times -> r_data 0x3C, then 0x80, then 0 with empty=1.
- Fill/overrun: write 0x00..0x07 -> full=1, count=8. Write 0xFF -> dropped, overrun=1. Pop all eight -> 0x00..0x07 in order, overrun still 1. Then flush -> overrun=0.
- Full simultaneous: with 8 stored words, assert w_enable (0x55) and r_enable together -> count stays 8, overrun=0. 0x55 emerges after the seven older words.
- Empty corner: r_enable alone while empty -> no change, count=0. w_enable (0x11) and r_enable together while empty -> count=1, r_data=0x11.
- Wrap-around: 20 interleaved write/pop pairs with 0..19, holding occupancy at 1-3 -> read sequence exactly 0..19, never full.
- Reset and flush mid-operation: store 5 words, pulse rst -> empty=1, count=0, r_data=0. Write 0x42 -> r_data=0x42. Store 3 words, assert flush together with w_enable (0x99) -> next cycle count=0, 0x99 absent.
